// File: rtl/uart_rx_fifo.sv
// Buffered 8N1 UART receiver: synchronised RX line, mid-bit sampling FSM,
// show-ahead byte FIFO and sticky framing/overflow flags.
module uart_rx_fifo #(
  parameter int unsigned CLK_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned ADDR_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              framing_err,
  output logic              overflow,
  input  logic              clr_err
);

  localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [ADDR_W:0]  FULL_CNT  = (ADDR_W + 1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic             sync1, rx_s, rx_s_d;
  logic             started, armed;
  logic             start_edge;

  logic [1:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       idx, idx_nx;
  logic [7:0]       shift, shift_nx;
  logic             push_req, frame_bad;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
  logic [ADDR_W:0]  count_nx;
  logic             pop, push, full, ovf_set;

  // Synchroniser plus edge-history flop; all idle-high out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      sync1  <= rx;
      rx_s   <= sync1;
      rx_s_d <= rx_s;
    end
  end

  // Edges are only trusted once the real line has been seen high after reset,
  // so a line held low through reset release cannot fake a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started <= 1'b0;
      armed   <= 1'b0;
    end else begin
      started <= 1'b1;
      armed   <= armed | (started & sync1);
    end
  end

  assign start_edge = armed & rx_s_d & ~rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      shift <= shift_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    idx_nx    = idx;
    shift_nx  = shift;
    push_req  = 1'b0;
    frame_bad = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_edge) begin
          state_nx = S_START;
          cnt_nx   = HALF_LOAD;
        end
      end
      S_START: begin
        if (cnt == '0) begin
          if (rx_s) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
          end else begin
            state_nx = S_DATA;
            idx_nx   = '0;
            cnt_nx   = BIT_LOAD;
          end
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt == '0) begin
          shift_nx[idx] = rx_s;
          cnt_nx        = BIT_LOAD;
          if (idx == 3'd7) begin
            state_nx = S_STOP;
          end else begin
            idx_nx = idx + 3'd1;
          end
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt == '0) begin
          state_nx  = S_IDLE;
          cnt_nx    = '0;
          push_req  = rx_s;
          frame_bad = ~rx_s;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // FIFO control: a pop frees a slot in the same cycle as a push into a full FIFO.
  assign pop     = rd_en & rd_valid;
  assign full    = (count == FULL_CNT);
  assign push    = push_req & (~full | pop);
  assign ovf_set = push_req & full & ~pop;

  always_comb begin
    wr_ptr_nx = push ? wr_ptr + ADDR_W'(1) : wr_ptr;
    rd_ptr_nx = pop  ? rd_ptr + ADDR_W'(1) : rd_ptr;
    case ({push, pop})
      2'b10:   count_nx = count + (ADDR_W + 1)'(1);
      2'b01:   count_nx = count - (ADDR_W + 1)'(1);
      default: count_nx = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= shift;
    end
  end

  // Registered show-ahead head: bypass the byte being written when it becomes the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      wr_ptr   <= wr_ptr_nx;
      rd_ptr   <= rd_ptr_nx;
      count    <= count_nx;
      rd_valid <= (count_nx != '0);
      if (count_nx != '0) begin
        if (push && (wr_ptr == rd_ptr_nx)) begin
          rd_data <= shift;
        end else begin
          rd_data <= mem[rd_ptr_nx];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      framing_err <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (frame_bad) begin
        framing_err <= 1'b1;
      end else if (clr_err) begin
        framing_err <= 1'b0;
      end
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks per bit.
module tb_uart_rx_fifo;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [AW:0]   count;
  logic          framing_err;
  logic          overflow;
  logic          clr_err;

  int n_checks = 0;
  int n_fail   = 0;

  int         rise_cyc;
  int         hi_cyc;
  int         max_cnt;
  logic       rd_hold;
  logic [7:0] seen[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_PER_BIT(CPB),
    .FIFO_DEPTH (DEPTH),
    .ADDR_W     (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .count      (count),
    .framing_err(framing_err),
    .overflow   (overflow),
    .clr_err    (clr_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick(1);
    rd_en = rd_hold;
  endtask

  // Drive one frame (start, 8 data LSB first, stop) for ncyc cycles, watching outputs.
  task automatic send_frame(input logic [7:0] data, input logic stop,
                            input int pop_cyc, input int ncyc);
    logic [9:0] frame;
    logic       prev;
    frame    = {stop, data, 1'b0};
    rise_cyc = -1;
    for (int i = 0; i < ncyc; i++) begin
      rx    = frame[i / CPB];
      rd_en = rd_hold | (i == pop_cyc);
      prev  = rd_valid;
      tick(1);
      if (rd_valid && !prev && rise_cyc < 0) rise_cyc = i + 1;
      if (rd_valid) begin
        hi_cyc++;
        seen.push_back(rd_data);
      end
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    rd_en = rd_hold;
  endtask

  task automatic send(input logic [7:0] data);
    send_frame(data, 1'b1, -1, 10 * CPB);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    rx      = 1'b1;
    rd_en   = 1'b0;
    rd_hold = 1'b0;
    clr_err = 1'b0;
    hi_cyc  = 0;
    max_cnt = 0;
    tick(3);
    check("rst_valid", rd_valid, 0);
    check("rst_count", count, 0);
    check("rst_data", rd_data, 0);
    check("rst_ferr", framing_err, 0);
    check("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    tick(5);

    // Back-to-back 0x55, 0xA3
    send(8'h55);
    check("lat_55", 32'((rise_cyc >= 154) && (rise_cyc <= 157)), 1);
    check("b2b_valid", rd_valid, 1);
    check("b2b_data0", rd_data, 8'h55);
    check("b2b_count1", count, 1);
    send(8'hA3);
    check("b2b_count2", count, 2);
    pop_one();
    check("b2b_data1", rd_data, 8'hA3);
    check("b2b_count3", count, 1);
    pop_one();
    check("b2b_empty", rd_valid, 0);
    check("b2b_count4", count, 0);
    check("b2b_ferr", framing_err, 0);
    check("b2b_ovf", overflow, 0);

    // Glitch shorter than half a bit
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(2 * CPB);
    check("glitch_valid", rd_valid, 0);
    check("glitch_count", count, 0);
    check("glitch_ferr", framing_err, 0);
    send(8'h7E);
    check("glitch_data", rd_data, 8'h7E);
    check("glitch_count2", count, 1);
    pop_one();

    // Framing error then recovery
    send_frame(8'h3C, 1'b0, -1, 10 * CPB);
    check("ferr_set", framing_err, 1);
    check("ferr_count", count, 0);
    rx = 1'b1;
    tick(CPB);
    send(8'h3C);
    check("ferr_rx_data", rd_data, 8'h3C);
    check("ferr_rx_count", count, 1);
    check("ferr_sticky", framing_err, 1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("ferr_clr", framing_err, 0);
    check("ferr_clr_count", count, 1);
    pop_one();

    // Fill past full
    for (int k = 0; k <= 16; k++) send(8'(k));
    check("ovf_count", count, 16);
    check("ovf_set", overflow, 1);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("ovf_rd%0d", k), rd_data, 32'(k));
      pop_one();
    end
    check("ovf_drained", rd_valid, 0);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("ovf_clr", overflow, 0);
    for (int k = 0; k < 16; k++) send(8'(8'h20 + k));
    check("full_count", count, 16);
    send_frame(8'h30, 1'b1, 154, 10 * CPB);
    check("fullpop_count", count, 16);
    check("fullpop_ovf", overflow, 0);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("fullpop_rd%0d", k), rd_data, 32'(8'h21 + k));
      pop_one();
    end
    check("fullpop_empty", count, 0);

    // Reset mid-frame (DATA index 4), line low through release
    send(8'h99);
    send_frame(8'h00, 1'b1, -1, 85);
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check("mrst_count", count, 0);
    check("mrst_valid", rd_valid, 0);
    check("mrst_data", rd_data, 0);
    check("mrst_ovf", overflow, 0);
    tick(12 * CPB);
    check("mrst_low_count", count, 0);
    check("mrst_low_ferr", framing_err, 0);
    rx = 1'b1;
    tick(CPB);
    send(8'hC1);
    check("mrst_data2", rd_data, 8'hC1);
    check("mrst_count2", count, 1);
    pop_one();

    // rd_en held high while five bytes stream in
    rd_hold = 1'b1;
    hi_cyc  = 0;
    max_cnt = 0;
    seen.delete();
    for (int k = 1; k <= 5; k++) send(8'(8'h11 * k));
    tick(2);
    rd_hold = 1'b0;
    rd_en   = 1'b0;
    check("hold_hi_cycles", 32'(hi_cyc), 5);
    check("hold_max_count", 32'(max_cnt), 1);
    check("hold_seen", 32'(seen.size()), 5);
    for (int k = 0; k < 5 && k < seen.size(); k++)
      check($sformatf("hold_byte%0d", k), seen[k], 32'(8'h11 * (k + 1)));
    check("hold_final_count", count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
